// File: rtl/accel_fir_filter.sv
// Sequential-MAC FIR for one accelerometer axis: one multiplier shared over TAPS cycles, and the result is valid TAPS+1 cycles after a sample is accepted.
// While busy, in_ready is low, incoming samples are dropped and counted, and coefficient writes are rejected with a coef_err pulse.
module accel_fir_filter #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 8,
  parameter int ACC_W     = 40,
  parameter int OUT_SHIFT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       sample_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              coef_we,
  input  logic [4:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_err,
  output logic [31:0]       out_data,
  output logic              out_valid,
  output logic              busy,
  output logic [7:0]        drop_count
);

  localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  // One extra coefficient bit so the reset value 1<<OUT_SHIFT (unity gain) is representable.
  localparam int CW = COEF_W + 1;
  localparam int PW = DATA_W + CW;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(TAPS - 1);
  localparam logic [5:0]              TAPS_L   = 6'(TAPS);
  localparam logic signed [CW-1:0]    COEF_ONE = CW'(1) << OUT_SHIFT;
  localparam logic signed [ACC_W-1:0] RND      = ACC_W'(1) << (OUT_SHIFT - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO   = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                    state, state_nxt;
  logic signed [DATA_W-1:0]  x    [TAPS];
  logic signed [CW-1:0]      coef [TAPS];
  logic signed [ACC_W-1:0]   acc, acc_nxt, acc_rnd, acc_shr;
  logic signed [PW-1:0]      prod;
  logic [IDX_W-1:0]          idx;
  logic [DATA_W-1:0]         res;
  logic                      smp_take, last_tap, coef_ok;
  logic                      unused_hi;

  assign unused_hi = ^sample_in[31:DATA_W];
  assign in_ready  = ~busy;
  assign last_tap  = (idx == LAST_IDX);
  assign coef_ok   = ({1'b0, coef_addr} < TAPS_L);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    smp_take  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          smp_take  = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        busy = 1'b1;
        if (last_tap) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Final accumulation, rounding and saturation are folded into the last MAC cycle
  // so the registered result is already visible during DONE.
  always_comb begin
    prod    = $signed({{CW{x[idx][DATA_W-1]}}, x[idx]}) *
              $signed({{DATA_W{coef[idx][CW-1]}}, coef[idx]});
    acc_nxt = acc + $signed({{(ACC_W - PW){prod[PW-1]}}, prod});
    acc_rnd = acc_nxt + RND;
    acc_shr = acc_rnd >>> OUT_SHIFT;
    if (acc_shr > SAT_HI)      res = SAT_HI[DATA_W-1:0];
    else if (acc_shr < SAT_LO) res = SAT_LO[DATA_W-1:0];
    else                       res = acc_shr[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        x[k]    <= '0;
        coef[k] <= (k == 0) ? COEF_ONE : '0;
      end
      acc        <= '0;
      idx        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      coef_err   <= 1'b0;
      drop_count <= '0;
    end else begin
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      if (coef_we) begin
        if (coef_ok && !busy) coef[coef_addr[IDX_W-1:0]] <= $signed({coef_data[COEF_W-1], coef_data});
        else                  coef_err <= 1'b1;
      end
      if (in_valid && busy && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (smp_take) begin
        x[0] <= sample_in[DATA_W-1:0];
        for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
        acc <= '0;
        idx <= '0;
      end
      if (state == MAC) begin
        acc <= acc_nxt;
        idx <= idx + 1'b1;
        if (last_tap) begin
          out_data  <= {{(32 - DATA_W){res[DATA_W-1]}}, res};
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_accel_fir_filter.sv
// Randomized and directed bench for accel_fir_filter with a queue scoreboard and an arithmetic reference model.
module tb_accel_fir_filter;
  localparam int TAPS = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] sample_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        coef_we = 1'b0;
  logic [4:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic        coef_err;
  logic [31:0] out_data;
  logic        out_valid;
  logic        busy;
  logic [7:0]  drop_count;

  accel_fir_filter dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .in_valid(in_valid), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int ov_seen = 0;

  typedef struct {
    logic [31:0] dat;
    int          at;
  } exp_t;
  exp_t exp_q[$];

  int m_x[TAPS];
  int m_c[TAPS];
  int m_drops;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Filter output from first principles: dot product, round half up, clamp to 16-bit.
  function automatic logic [31:0] model_out();
    longint sum = 0;
    longint q, r;
    for (int k = 0; k < TAPS; k++) sum += longint'(m_x[k]) * longint'(m_c[k]);
    q = sum + 16384;
    r = q / 32768;
    if (q < 0 && (q % 32768) != 0) r = r - 1;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return 32'(r);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_x[k] = 0;
      m_c[k] = (k == 0) ? 32768 : 0;
    end
    m_drops = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_drop_count", {24'b0, drop_count}, 32'h0);
    chk("rst_coef_err", {31'b0, coef_err}, 32'h0);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) fail_now("wait_ready");
  endtask

  // Accept one sample, optionally with a coefficient write in the same cycle.
  task automatic send(input logic [15:0] s, input logic we, input logic [4:0] addr, input logic [15:0] cd);
    logic [31:0] r;
    wait_ready();
    r = $urandom();
    sample_in = {r[31:16], s};
    in_valid  = 1'b1;
    coef_we   = we;
    coef_addr = addr;
    coef_data = cd;
    if (we && addr < TAPS) m_c[addr] = int'($signed(cd));
    for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = int'($signed(s));
    exp_q.push_back('{dat: model_out(), at: cyc + TAPS + 1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    if (we) chk("same_cycle_coef_err", {31'b0, coef_err}, {31'b0, (addr >= TAPS)});
  endtask

  task automatic send_s(input logic [15:0] s);
    send(s, 1'b0, 5'd0, 16'd0);
  endtask

  task automatic write_coef(input logic [4:0] addr, input logic [15:0] cd, input logic exp_err, input logic idle_first);
    if (idle_first) wait_ready();
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = cd;
    @(posedge clk); #1;
    coef_we = 1'b0;
    chk("coef_err", {31'b0, coef_err}, {31'b0, exp_err});
    if (!exp_err) m_c[addr] = int'($signed(cd));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'h0);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      ov_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: out_valid with %h, expected none", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", out_data, e.dat);
        chk("out_latency", 32'(cyc), 32'(e.at));
      end
    end
  end

  initial begin
    int ov_before;
    model_reset();

    // Passthrough after reset
    do_reset();
    send_s(16'd100);
    drain();
    chk("pass_100", out_data, 32'd100);
    send_s(-16'sd5);
    drain();
    chk("pass_neg5", out_data, 32'hFFFF_FFFB);

    // Moving average of 8
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(5'(k), 16'd4096, 1'b0, 1'b1);
    for (int k = 1; k <= TAPS; k++) begin
      send_s(16'd800);
      drain();
      chk("avg_step", out_data, 32'(100 * k));
    end

    // Saturation both ways
    for (int k = 0; k < TAPS; k++) write_coef(5'(k), 16'd32767, 1'b0, 1'b1);
    for (int k = 0; k < TAPS; k++) send_s(16'd32767);
    drain();
    chk("sat_pos", out_data, 32'h0000_7FFF);
    for (int k = 0; k < TAPS; k++) send_s(16'h8000);
    drain();
    chk("sat_neg", out_data, 32'hFFFF_8000);

    // Drops while busy
    do_reset();
    send_s(16'd321);
    repeat (2) @(posedge clk);
    #1;
    sample_in = 32'h0000_1111;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    m_drops++;
    drain();
    chk("drop_one", {24'b0, drop_count}, 32'd1);
    chk("drop_result", out_data, 32'd321);
    for (int n = 0; n < 34; n++) begin
      send_s(16'($urandom_range(0, 65535)));
      for (int i = 0; i < TAPS + 1; i++) begin
        sample_in = $urandom();
        in_valid  = 1'b1;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      m_drops = (m_drops + TAPS + 1 > 255) ? 255 : m_drops + TAPS + 1;
    end
    drain();
    chk("drop_sat", {24'b0, drop_count}, 32'(m_drops));
    chk("drop_sat_255", {24'b0, drop_count}, 32'd255);

    // Rejected coefficient writes
    do_reset();
    send_s(16'd77);
    write_coef(5'd0, 16'd0, 1'b1, 1'b0);
    drain();
    send_s(16'd55);
    drain();
    chk("busy_write_ignored", out_data, 32'd55);
    write_coef(5'd9, 16'd1234, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("coef_err_pulse_end", {31'b0, coef_err}, 32'h0);
    send_s(16'd66);
    drain();
    chk("bad_addr_ignored", out_data, 32'd66);

    // Reset in the middle of a MAC
    send_s(16'd123);
    repeat (3) @(posedge clk);
    ov_before = ov_seen;
    do_reset();
    repeat (TAPS + 4) @(posedge clk);
    #1;
    chk("abort_no_valid", 32'(ov_seen), 32'(ov_before));
    chk("abort_out_zero", out_data, 32'h0);
    send_s(16'd42);
    drain();
    chk("after_abort", out_data, 32'd42);

    // Randomized traffic with runtime coefficient updates
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int sel;
      logic [4:0] a;
      sel = $urandom_range(0, 3);
      a   = 5'($urandom_range(0, 9));
      if (sel == 0) write_coef(a, 16'($urandom()), (a >= TAPS), 1'b1);
      if (sel == 1) send(16'($urandom()), 1'b1, a, 16'($urandom()));
      else          send_s(16'($urandom()));
      repeat ($urandom_range(0, 12)) @(posedge clk);
      #1;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
